// File: rtl/surf_cout_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : surf_cout_align_ctrl
// Brief    : IDELAY eye sweep + bitslip training sequencer for the SURF COUT/DOUT
//            receive PHY. Optional macro SURF_ALIGN_EYE_MAP_EN adds eye_map_o.
// Revision : 1.0
// ============================================================================
module surf_cout_align_ctrl #(
    parameter logic [3:0] COUT_TRAIN    = 4'b1000,
    parameter logic [7:0] DOUT_TRAIN    = 8'hB8,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         SAMPLES       = 256,
    parameter int         MAX_TAP       = 31,
    parameter int         MIN_EYE       = 4
) (
    input  logic        sysclk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        target_i,
    input  logic [3:0]  cout_i,
    input  logic [7:0]  dout_i,
    input  logic [5:0]  idelay_current_i,
    input  logic [5:0]  idelay_dout_current_i,
    output logic        iserdes_rst_o,
    output logic        iserdes_bitslip_o,
    output logic        iserdes_dout_bitslip_o,
    output logic [5:0]  idelay_value_o,
    output logic        idelay_load_o,
    output logic        idelay_dout_load_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [4:0]  eye_start_o,
    output logic [5:0]  eye_width_o,
    output logic [31:0] eye_map_o
);

    localparam int          C_CNT_W       = 16;
    localparam logic [15:0] C_RST_LAST    = 16'd3;
    localparam logic [15:0] C_SETTLE_LAST = C_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [15:0] C_SAMPLE_LAST = C_CNT_W'(SAMPLES - 1);
    localparam logic [4:0]  C_MAX_TAP     = 5'(MAX_TAP);
    localparam logic [5:0]  C_MIN_EYE     = 6'(MIN_EYE);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RST     = 4'd1,
        S_LOAD    = 4'd2,
        S_SETTLE  = 4'd3,
        S_CHECK   = 4'd4,
        S_NEXT    = 4'd5,
        S_EVAL    = 4'd6,
        S_CLOAD   = 4'd7,
        S_CSETTLE = 4'd8,
        S_VERIFY  = 4'd9,
        S_SLIP    = 4'd10,
        S_SWAIT   = 4'd11,
        S_DONE    = 4'd12,
        S_ERR     = 4'd13
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [4:0]  r_tap;
    logic        r_target;
    logic [7:0]  r_first;
    logic        r_pass;
    logic [5:0]  r_cur_len;
    logic [4:0]  r_cur_start;
    logic [5:0]  r_best_len;
    logic [4:0]  r_best_start;
    logic [3:0]  r_slip_cnt;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [4:0]  r_eye_start;
    logic [5:0]  r_eye_width;
    logic        r_bitslip_c;
    logic        r_bitslip_d;

    logic [7:0]  w_word;
    logic        w_rot_ok;
    logic        w_match;
    logic        w_pass;
    logic [5:0]  w_readback;
    logic        w_rb_ok;
    logic [3:0]  w_slip_max;
    logic [4:0]  w_centre;
    logic [5:0]  w_cur_len_nxt;
    logic [4:0]  w_cur_start_nxt;
    logic [1:0]  w_err_code;
    logic        w_load;

    // True when the word is any rotation of the lane's training pattern.
    function automatic logic is_rot4(input logic [3:0] w);
        logic [3:0] rot;
        logic       hit;
        rot = COUT_TRAIN;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hit = hit | (w == rot);
            rot = {rot[2:0], rot[3]};
        end
        return hit;
    endfunction

    function automatic logic is_rot8(input logic [7:0] w);
        logic [7:0] rot;
        logic       hit;
        rot = DOUT_TRAIN;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            hit = hit | (w == rot);
            rot = {rot[6:0], rot[7]};
        end
        return hit;
    endfunction

    assign w_word       = r_target ? dout_i : {4'b0000, cout_i};
    assign w_rot_ok     = r_target ? is_rot8(dout_i) : is_rot4(cout_i);
    assign w_match      = r_target ? (dout_i == DOUT_TRAIN) : (cout_i == COUT_TRAIN);
    assign w_pass       = (r_cnt == 16'd0) ? w_rot_ok : (r_pass && (w_word == r_first));
    assign w_readback   = r_target ? idelay_dout_current_i : idelay_current_i;
    assign w_rb_ok      = (w_readback[5] == 1'b0) && (w_readback[4:0] == r_tap);
    assign w_slip_max   = r_target ? 4'd8 : 4'd4;
    assign w_centre     = r_best_start + r_best_len[5:1];
    assign w_cur_len_nxt   = w_pass ? (r_cur_len + 6'd1) : 6'd0;
    assign w_cur_start_nxt = (w_pass && (r_cur_len == 6'd0)) ? r_tap : r_cur_start;

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_err_code    = 2'd0;
        w_load        = 1'b0;
        iserdes_rst_o = 1'b0;
        case (r_state)
            S_IDLE:    if (start_i) w_state_nxt = S_RST;
            S_RST: begin
                iserdes_rst_o = 1'b1;
                if (r_cnt == C_RST_LAST) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE:  if (r_cnt == C_SETTLE_LAST) w_state_nxt = S_CHECK;
            S_CHECK:   if (r_cnt == C_SAMPLE_LAST) w_state_nxt = S_NEXT;
            S_NEXT:    w_state_nxt = (r_tap == C_MAX_TAP) ? S_EVAL : S_LOAD;
            S_EVAL: begin
                if (r_best_len < C_MIN_EYE) begin
                    w_state_nxt = S_ERR;
                    w_err_code  = 2'd1;
                end else begin
                    w_state_nxt = S_CLOAD;
                end
            end
            S_CLOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_CSETTLE;
            end
            S_CSETTLE: if (r_cnt == C_SETTLE_LAST) w_state_nxt = S_VERIFY;
            S_VERIFY: begin
                if (w_rb_ok) begin
                    w_state_nxt = S_SLIP;
                end else begin
                    w_state_nxt = S_ERR;
                    w_err_code  = 2'd3;
                end
            end
            S_SLIP: begin
                if (w_match) begin
                    w_state_nxt = S_DONE;
                end else if (r_slip_cnt == w_slip_max) begin
                    w_state_nxt = S_ERR;
                    w_err_code  = 2'd2;
                end else begin
                    w_state_nxt = S_SWAIT;
                end
            end
            S_SWAIT:   if (r_cnt == C_SETTLE_LAST) w_state_nxt = S_SLIP;
            S_DONE:    w_state_nxt = S_IDLE;
            S_ERR:     w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt        <= '0;
            r_tap        <= '0;
            r_target     <= 1'b0;
            r_first      <= '0;
            r_pass       <= 1'b0;
            r_cur_len    <= '0;
            r_cur_start  <= '0;
            r_best_len   <= '0;
            r_best_start <= '0;
            r_slip_cnt   <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= '0;
            r_eye_start  <= '0;
            r_eye_width  <= '0;
            r_bitslip_c  <= 1'b0;
            r_bitslip_d  <= 1'b0;
        end else begin
            // Every state's dwell is timed from zero on entry.
            r_cnt       <= (w_state_nxt != r_state) ? 16'd0 : (r_cnt + 16'd1);
            r_bitslip_c <= 1'b0;
            r_bitslip_d <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_target     <= target_i;
                        r_tap        <= '0;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_err_code   <= '0;
                        r_eye_start  <= '0;
                        r_eye_width  <= '0;
                        r_cur_len    <= '0;
                        r_cur_start  <= '0;
                        r_best_len   <= '0;
                        r_best_start <= '0;
                        r_slip_cnt   <= '0;
                    end
                end
                S_CHECK: begin
                    if (r_cnt == 16'd0) r_first <= w_word;
                    r_pass <= w_pass;
                    if (r_cnt == C_SAMPLE_LAST) begin
                        r_cur_len   <= w_cur_len_nxt;
                        r_cur_start <= w_cur_start_nxt;
                        // Strict compare keeps the earliest of equal-width eyes.
                        if (w_cur_len_nxt > r_best_len) begin
                            r_best_len   <= w_cur_len_nxt;
                            r_best_start <= w_cur_start_nxt;
                        end
                    end
                end
                S_NEXT: begin
                    if (r_tap != C_MAX_TAP) r_tap <= r_tap + 5'd1;
                end
                S_EVAL: begin
                    r_eye_start <= r_best_start;
                    r_eye_width <= r_best_len;
                    if (r_best_len >= C_MIN_EYE) r_tap <= w_centre;
                end
                S_SLIP: begin
                    if (!w_match && (r_slip_cnt != w_slip_max)) begin
                        r_bitslip_c <= ~r_target;
                        r_bitslip_d <= r_target;
                        r_slip_cnt  <= r_slip_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
                r_done <= 1'b1;
            end
            if ((w_state_nxt == S_ERR) && (r_state != S_ERR)) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

`ifdef SURF_ALIGN_EYE_MAP_EN
    logic [31:0] r_eye_map;

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_eye_map <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_eye_map <= '0;
        end else if ((r_state == S_CHECK) && (r_cnt == C_SAMPLE_LAST)) begin
            r_eye_map[r_tap] <= w_pass;
        end
    end

    assign eye_map_o = r_eye_map;
`else
    assign eye_map_o = 32'd0;
`endif

    assign busy_o                 = (r_state != S_IDLE);
    assign done_o                 = r_done;
    assign err_o                  = r_err;
    assign err_code_o             = r_err_code;
    assign eye_start_o            = r_eye_start;
    assign eye_width_o            = r_eye_width;
    assign idelay_value_o         = {1'b0, r_tap};
    assign idelay_load_o          = w_load & ~r_target;
    assign idelay_dout_load_o     = w_load & r_target;
    assign iserdes_bitslip_o      = r_bitslip_c;
    assign iserdes_dout_bitslip_o = r_bitslip_d;

endmodule
`default_nettype wire

// File: tb/tb_surf_cout_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_surf_cout_align_ctrl
// Brief    : Self-checking bench for surf_cout_align_ctrl with a behavioural PHY.
// Revision : 1.0
// ============================================================================
module tb_surf_cout_align_ctrl;

    localparam int          SETTLE = 4;
    localparam int          SAMP   = 8;
    localparam int          MAXT   = 31;
    localparam int          MINE   = 4;
    localparam logic [3:0]  CT     = 4'b1000;
    localparam logic [7:0]  DT     = 8'hB8;

    logic        clk = 1'b0;
    logic        rst_n_i, start_i, target_i;
    logic [3:0]  cout_i;
    logic [7:0]  dout_i;
    logic [5:0]  idelay_current_i, idelay_dout_current_i;
    logic        iserdes_rst_o, iserdes_bitslip_o, iserdes_dout_bitslip_o;
    logic [5:0]  idelay_value_o;
    logic        idelay_load_o, idelay_dout_load_o;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_code_o;
    logic [4:0]  eye_start_o;
    logic [5:0]  eye_width_o;
    logic [31:0] eye_map_o;

    always #5 clk = ~clk;

    surf_cout_align_ctrl #(
        .COUT_TRAIN(CT), .DOUT_TRAIN(DT), .SETTLE_CYCLES(SETTLE),
        .SAMPLES(SAMP), .MAX_TAP(MAXT), .MIN_EYE(MINE)
    ) dut (
        .sysclk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .target_i(target_i),
        .cout_i(cout_i), .dout_i(dout_i),
        .idelay_current_i(idelay_current_i), .idelay_dout_current_i(idelay_dout_current_i),
        .iserdes_rst_o(iserdes_rst_o), .iserdes_bitslip_o(iserdes_bitslip_o),
        .iserdes_dout_bitslip_o(iserdes_dout_bitslip_o), .idelay_value_o(idelay_value_o),
        .idelay_load_o(idelay_load_o), .idelay_dout_load_o(idelay_dout_load_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
        .eye_start_o(eye_start_o), .eye_width_o(eye_width_o), .eye_map_o(eye_map_o)
    );

    typedef struct {
        bit          tgt;
        logic [31:0] mask;
        int          rot;
        bit          rbz;
        bit          sd;
        int          poke;
        int          done;
        int          code;
        int          st;
        int          wd;
        int          val;
        int          slips;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // PHY model state: pass mask over taps, initial rotation, fault modes.
    logic [31:0] m_mask = '0;
    int          m_rot = 0;
    bit          m_rbz = 0;
    bit          m_sd = 0;
    int          cyc = 0;
    int          tap_c = 0, tap_d = 0, slips_c = 0, slips_d = 0;
    int          n_load_c = 0, n_load_d = 0, n_bs_c = 0, n_bs_d = 0, n_rst = 0;
    int          first_load = -1, wide = 0;
    bit          prev_lc = 0, prev_ld = 0, prev_bc = 0, prev_bd = 0;

    function automatic logic [3:0] rotl4(input logic [3:0] v, input int n);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] outs_vec();
        return {5'd0, busy_o, done_o, err_o, err_code_o, eye_start_o, eye_width_o,
                idelay_value_o, idelay_load_o, idelay_dout_load_o, iserdes_bitslip_o,
                iserdes_dout_bitslip_o, iserdes_rst_o};
    endfunction

    // Behavioural PHY: taps in the mask give a stable rotated pattern, others toggle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if ((idelay_load_o && prev_lc) || (idelay_dout_load_o && prev_ld) ||
            (iserdes_bitslip_o && prev_bc) || (iserdes_dout_bitslip_o && prev_bd))
            wide = wide + 1;
        prev_lc = idelay_load_o;
        prev_ld = idelay_dout_load_o;
        prev_bc = iserdes_bitslip_o;
        prev_bd = iserdes_dout_bitslip_o;
        if (idelay_load_o) begin
            tap_c = int'(idelay_value_o);
            n_load_c = n_load_c + 1;
            if (first_load < 0) first_load = int'(idelay_value_o);
        end
        if (idelay_dout_load_o) begin
            tap_d = int'(idelay_value_o);
            n_load_d = n_load_d + 1;
            if (first_load < 0) first_load = int'(idelay_value_o);
        end
        if (iserdes_rst_o) begin
            n_rst = n_rst + 1;
            slips_c = 0;
            slips_d = 0;
        end
        if (iserdes_bitslip_o) begin
            n_bs_c = n_bs_c + 1;
            slips_c = slips_c + 1;
        end
        if (iserdes_dout_bitslip_o) begin
            n_bs_d = n_bs_d + 1;
            slips_d = slips_d + 1;
        end
        cout_i = m_mask[tap_c % 32] ? rotl4(CT, (m_rot + (m_sd ? 0 : slips_c)) % 4) : 4'(cyc);
        dout_i = m_mask[tap_d % 32] ? rotl8(DT, (m_rot + (m_sd ? 0 : slips_d)) % 8) : 8'(cyc);
        idelay_current_i      = m_rbz ? 6'd0 : 6'(tap_c);
        idelay_dout_current_i = m_rbz ? 6'd0 : 6'(tap_d);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: widest all-pass window (earliest on ties), then eye/slip rules.
    task automatic model(inout vec_t v);
        logic [63:0] m, ones;
        int W;
        m = {32'd0, v.mask};
        v.st = 0;
        v.wd = 0;
        for (int w = 32; w >= 1; w--) begin
            if (v.wd == 0) begin
                ones = (64'd1 << w) - 64'd1;
                for (int s = 0; s + w <= 32; s++)
                    if (v.wd == 0 && ((m >> s) & ones) == ones) begin
                        v.st = s;
                        v.wd = w;
                    end
            end
        end
        W = v.tgt ? 8 : 4;
        v.done  = 0;
        v.slips = 0;
        if (v.wd < MINE) begin
            v.code = 1;
            v.val  = MAXT;
        end else begin
            v.val = (v.st + v.wd / 2) % 32;
            if (v.rbz && v.val != 0) begin
                v.code = 3;
            end else if (v.sd && (v.rot % W) != 0) begin
                v.code  = 2;
                v.slips = W;
            end else begin
                v.code  = 0;
                v.done  = 1;
                v.slips = (W - v.rot % W) % W;
            end
        end
    endtask

    task automatic run_case(input string nm, input vec_t v);
        int bound;
        logic [31:0] exp_map;
        m_mask = v.mask;
        m_rot  = v.rot;
        m_rbz  = v.rbz;
        m_sd   = v.sd;
        n_load_c = 0; n_load_d = 0; n_bs_c = 0; n_bs_d = 0; n_rst = 0;
        first_load = -1;
        wide = 0;
        @(negedge clk);
        start_i  = 1'b1;
        target_i = v.tgt;
        @(negedge clk);
        start_i = 1'b0;
        bound = 0;
        while (busy_o && bound < 20000) begin
            @(negedge clk);
            bound = bound + 1;
            if (bound == v.poke) begin
                start_i  = 1'b1;
                target_i = ~v.tgt;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
`ifdef SURF_ALIGN_EYE_MAP_EN
        exp_map = v.mask;
`else
        exp_map = 32'd0;
`endif
        chk({nm, ".finished"}, 32'(busy_o), 32'd0);
        chk({nm, ".done"}, 32'(done_o), 32'(v.done));
        chk({nm, ".err"}, 32'(err_o), 32'(v.done == 0));
        chk({nm, ".code"}, 32'(err_code_o), 32'(v.code));
        chk({nm, ".eye_start"}, 32'(eye_start_o), 32'(v.st));
        chk({nm, ".eye_width"}, 32'(eye_width_o), 32'(v.wd));
        chk({nm, ".value"}, 32'(idelay_value_o), 32'(v.val));
        chk({nm, ".slips"}, 32'(v.tgt ? n_bs_d : n_bs_c), 32'(v.slips));
        chk({nm, ".other_slips"}, 32'(v.tgt ? n_bs_c : n_bs_d), 32'd0);
        chk({nm, ".loads"}, 32'(v.tgt ? n_load_d : n_load_c), (v.code == 1) ? 32'd32 : 32'd33);
        chk({nm, ".other_loads"}, 32'(v.tgt ? n_load_c : n_load_d), 32'd0);
        chk({nm, ".rst_cycles"}, 32'(n_rst), 32'd4);
        chk({nm, ".first_tap"}, 32'(first_load), 32'd0);
        chk({nm, ".pulse_width"}, 32'(wide), 32'd0);
        chk({nm, ".eye_map"}, eye_map_o, exp_map);
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        int bound;
        int W;
        //          tgt mask          rot rbz sd poke done code st wd val slips
        tbl[0] = '{0, 32'h001FFC00, 2, 0, 0, 0,   1, 0, 10, 11, 15, 2};
        tbl[1] = '{1, 32'h0000FFE0, 5, 0, 0, 0,   1, 0,  5, 11, 10, 3};
        tbl[2] = '{0, 32'h01F0007C, 1, 0, 0, 0,   1, 0,  2,  5,  4, 3};
        tbl[3] = '{1, 32'hF0000000, 0, 0, 0, 0,   1, 0, 28,  4, 30, 0};
        tbl[4] = '{0, 32'h00000700, 2, 0, 0, 0,   0, 1,  8,  3, 31, 0};
        tbl[5] = '{1, 32'h001FFC00, 2, 1, 0, 0,   0, 3, 10, 11, 15, 0};
        tbl[6] = '{0, 32'h001FFC00, 1, 0, 1, 0,   0, 2, 10, 11, 15, 4};
        tbl[7] = '{1, 32'hFFFFFFFF, 3, 0, 1, 0,   0, 2,  0, 32, 16, 8};
        tbl[8] = '{0, 32'h00000000, 0, 0, 0, 0,   0, 1,  0,  0, 31, 0};
        tbl[9] = '{0, 32'h001FFC00, 2, 0, 0, 100, 1, 0, 10, 11, 15, 2};

        rst_n_i = 1'b0; start_i = 1'b0; target_i = 1'b0;
        cout_i = '0; dout_i = '0; idelay_current_i = '0; idelay_dout_current_i = '0;
        repeat (3) @(negedge clk);
        chk("reset.outputs", outs_vec(), 32'd0);
        chk("reset.eye_map", eye_map_o, 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_case($sformatf("tbl%0d", i), tbl[i]);

        // Abort in CHECK at tap 7, then rerun from tap 0.
        m_mask = 32'h001FFC00; m_rot = 2; m_rbz = 0; m_sd = 0; n_load_c = 0;
        @(negedge clk);
        start_i = 1'b1; target_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        bound = 0;
        while (n_load_c < 8 && bound < 2000) begin
            @(negedge clk);
            bound = bound + 1;
        end
        chk("abort.reached_tap7", 32'(tap_c), 32'd7);
        repeat (SETTLE + 2) @(negedge clk);
        chk("abort.busy_before", 32'(busy_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("abort.outputs", outs_vec(), 32'd0);
        chk("abort.eye_map", eye_map_o, 32'd0);
        @(negedge clk);
        rst_n_i = 1'b1;
        run_case("after_abort", tbl[0]);

        for (int i = 0; i < 12; i++) begin
            rv.tgt  = 1'($urandom_range(0, 1));
            W       = rv.tgt ? 8 : 4;
            rv.mask = '0;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                int s, w;
                s = int'($urandom_range(0, 31));
                w = int'($urandom_range(1, 12));
                for (int t = s; t < s + w && t < 32; t++) rv.mask[t] = 1'b1;
            end
            rv.rot  = int'($urandom_range(0, W - 1));
            rv.rbz  = ($urandom_range(0, 7) == 0);
            rv.sd   = ($urandom_range(0, 7) == 0);
            rv.poke = 0;
            model(rv);
            run_case($sformatf("rand%0d", i), rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
